usb_mem_arbiter: RTL and testbench

USB_MEM_ARBITER -- requirements
Module: usb_mem_arbiter

---
 rtl/usb_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_usb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_mem_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one single-cycle memory port.
// Alternating priority on contention, out-of-range/read+write error counting.
module usb_mem_arbiter #(
  parameter int NUM_WORDS = 1536,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  // requester 0
  input  logic [10:0]      m0_address,
  input  logic [3:0]       m0_byteenable,
  input  logic             m0_read,
  input  logic             m0_write,
  input  logic [31:0]      m0_writedata,
  output logic             m0_waitrequest,
  output logic [31:0]      m0_readdata,
  output logic             m0_readdatavalid,
  // requester 1
  input  logic [10:0]      m1_address,
  input  logic [3:0]       m1_byteenable,
  input  logic             m1_read,
  input  logic             m1_write,
  input  logic [31:0]      m1_writedata,
  output logic             m1_waitrequest,
  output logic [31:0]      m1_readdata,
  output logic             m1_readdatavalid,
  // memory port
  output logic [10:0]      mem_address,
  output logic [3:0]       mem_byteenable,
  output logic [31:0]      mem_writedata,
  output logic             mem_chipselect,
  output logic             mem_write,
  output logic             mem_clken,
  input  logic [31:0]      mem_readdata,
  // status
  output logic [ERR_W-1:0] err_count,
  output logic             last_grant
);

  // Handshake: a requester holds read/write until a cycle in which its
  // waitrequest is low; that cycle is the accept and occupies the memory port.

  logic act0, act1;
  logic win;
  logic accept;
  logic sel_read, sel_write;
  logic in_range;
  logic is_err;
  logic rd_only;

  logic             last_grant_q, last_grant_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             rvalid_q, rvalid_d;
  logic             rowner_q, rowner_d;
  logic             rzero_q, rzero_d;
  logic [31:0]      rdata;

  // Requests are masked while in reset so nothing is accepted or issued.
  always_comb begin
    act0      = (m0_read | m0_write) & reset_n;
    act1      = (m1_read | m1_write) & reset_n;
    win       = act1 & (~act0 | ~last_grant_q);
    accept    = act0 | act1;
    sel_read  = win ? m1_read  : m0_read;
    sel_write = win ? m1_write : m0_write;
    in_range  = ({21'd0, (win ? m1_address : m0_address)} < 32'(NUM_WORDS));
    rd_only   = sel_read & ~sel_write;
    is_err    = accept & (~in_range | (sel_read & sel_write));
  end

  always_comb begin
    mem_address    = win ? m1_address    : m0_address;
    mem_byteenable = win ? m1_byteenable : m0_byteenable;
    mem_writedata  = win ? m1_writedata  : m0_writedata;
    mem_chipselect = accept & in_range;
    mem_write      = accept & in_range & sel_write;
    mem_clken      = 1'b1;
    m0_waitrequest = ~(accept & ~win);
    m1_waitrequest = ~(accept & win);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    err_d        = err_q;
    rvalid_d     = accept & rd_only;
    rowner_d     = rowner_q;
    rzero_d      = rzero_q;
    if (accept) begin
      last_grant_d = win;
      rowner_d     = win;
      rzero_d      = ~in_range;
    end
    if (is_err && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      err_q        <= '0;
      rvalid_q     <= 1'b0;
      rowner_q     <= 1'b0;
      rzero_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      rvalid_q     <= rvalid_d;
      rowner_q     <= rowner_d;
      rzero_q      <= rzero_d;
    end
  end

  // Out-of-range reads never touched the memory, so the stale port output is masked.
  always_comb begin
    rdata            = rzero_q ? 32'd0 : mem_readdata;
    m0_readdatavalid = rvalid_q & ~rowner_q;
    m1_readdatavalid = rvalid_q & rowner_q;
    m0_readdata      = m0_readdatavalid ? rdata : 32'd0;
    m1_readdata      = m1_readdatavalid ? rdata : 32'd0;
    err_count        = err_q;
    last_grant       = last_grant_q;
  end

endmodule

// File: tb/tb_usb_mem_arbiter.sv
// Bench for usb_mem_arbiter: behavioural memory, directed vector table,
// reset/saturation sequences and randomized traffic against a reference model.
module tb_usb_mem_arbiter;

  localparam int NW = 1536;

  logic        clk, reset_n;
  logic [10:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;
  logic [7:0]  err_count;
  logic        last_grant;

  usb_mem_arbiter #(.NUM_WORDS(NW), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .err_count(err_count), .last_grant(last_grant)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory (registered read, byte-lane write) ----------------
  logic [31:0] mem [NW];
  logic [31:0] mem_q;
  assign mem_readdata = mem_q;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken && (int'(mem_address) < NW)) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_q <= mem[mem_address];
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [NW];
  int          m_lg, m_err;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd;

  int n_checks, n_errors;

  // observed values of the most recent step, for table comparisons
  logic        obs_rv0, obs_rv1, obs_lg, obs_w0, obs_w1, obs_cs, obs_mw;
  logic [31:0] obs_rd0, obs_rd1;
  logic [7:0]  obs_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lg  = 1;
    m_err = 0;
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    m_rd  = 32'd0;
  endtask

  task automatic drive_idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  // One bus cycle: check last cycle's returns, drive, check arbitration, advance model.
  task automatic step(input logic r0, w0, input logic [10:0] a0, input logic [3:0] be0,
                      input logic [31:0] d0, input logic r1, w1, input logic [10:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1);
    int          win;
    logic        acc, rd, wr, inr, e_cs;
    logic [10:0] ad;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    obs_rv0 = m0_readdatavalid; obs_rv1 = m1_readdatavalid;
    obs_rd0 = m0_readdata;      obs_rd1 = m1_readdata;
    obs_err = err_count;        obs_lg  = last_grant;
    check("rdv0", 32'(m0_readdatavalid), 32'(m_rv0));
    check("rdv1", 32'(m1_readdatavalid), 32'(m_rv1));
    check("rdata0", m0_readdata, m_rv0 ? m_rd : 32'd0);
    check("rdata1", m1_readdata, m_rv1 ? m_rd : 32'd0);
    check("err_count", 32'(err_count), 32'(m_err));
    check("last_grant", 32'(last_grant), 32'(m_lg));

    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    #1;
    acc = (r0 | w0) | (r1 | w1);
    if ((r0 | w0) && (r1 | w1)) win = (m_lg == 1) ? 0 : 1;
    else                        win = (r1 | w1) ? 1 : 0;
    ad = win ? a1 : a0;  be = win ? be1 : be0;  wd = win ? d1 : d0;
    rd = win ? r1 : r0;  wr = win ? w1 : w0;
    inr  = int'(ad) < NW;
    e_cs = acc && inr;
    obs_w0 = m0_waitrequest; obs_w1 = m1_waitrequest;
    obs_cs = mem_chipselect; obs_mw = mem_write;
    check("wait0", 32'(m0_waitrequest), 32'(!(acc && win == 0)));
    check("wait1", 32'(m1_waitrequest), 32'(!(acc && win == 1)));
    check("chipselect", 32'(mem_chipselect), 32'(e_cs));
    check("mem_write", 32'(mem_write), 32'(e_cs && wr));
    check("clken", 32'(mem_clken), 32'd1);
    if (e_cs) begin
      check("mem_address", 32'(mem_address), 32'(ad));
      if (wr) begin
        check("mem_be", 32'(mem_byteenable), 32'(be));
        check("mem_wdata", mem_writedata, wd);
      end
    end

    m_rv0 = acc && rd && !wr && win == 0;
    m_rv1 = acc && rd && !wr && win == 1;
    m_rd  = inr ? ref_mem[ad] : 32'd0;
    if (acc && (!inr || (rd && wr))) m_err = (m_err < 255) ? m_err + 1 : 255;
    if (acc && wr && inr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[ad][b*8 +: 8] = wd[b*8 +: 8];
    if (acc) m_lg = win;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0, w0; logic [10:0] a0;
    logic r1, w1; logic [10:0] a1;
    logic [3:0] be; logic [31:0] wd;
    logic e_w0, e_w1, e_cs, e_mw;
    logic e_rv0, e_rv1; logic [31:0] e_rd0, e_rd1;
    logic [7:0] e_err; logic e_lg;
  } vec_t;

  vec_t vecs [15];

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    mem[5]     = 32'hFFFF_FFFF;
    ref_mem[5] = 32'hFFFF_FFFF;
    mem_q      = '0;

    //          r0 w0 a0       r1 w1 a1       be    wd            w0 w1 cs mw rv0 rv1 rd0           rd1           err lg
    vecs[0]  = '{0, 0, 11'h000, 1, 0, 11'h600, 4'hF, 32'h0,        1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1};
    vecs[1]  = '{1, 0, 11'h010, 1, 0, 11'h020, 4'hF, 32'h0,        0, 1, 1, 0, 0, 1, 32'h0,        32'h0,        1, 1};
    vecs[2]  = '{1, 0, 11'h010, 1, 0, 11'h020, 4'hF, 32'h0,        1, 0, 1, 0, 1, 0, 32'hC0DE0010, 32'h0,        1, 0};
    vecs[3]  = '{1, 0, 11'h010, 1, 0, 11'h020, 4'hF, 32'h0,        0, 1, 1, 0, 0, 1, 32'h0,        32'hC0DE0020, 1, 1};
    vecs[4]  = '{1, 0, 11'h010, 1, 0, 11'h020, 4'hF, 32'h0,        1, 0, 1, 0, 1, 0, 32'hC0DE0010, 32'h0,        1, 0};
    vecs[5]  = '{0, 1, 11'h005, 0, 0, 11'h000, 4'h3, 32'hA5A5A5A5, 0, 1, 1, 1, 0, 1, 32'h0,        32'hC0DE0020, 1, 1};
    vecs[6]  = '{0, 0, 11'h000, 1, 0, 11'h005, 4'hF, 32'h0,        1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0};
    vecs[7]  = '{0, 0, 11'h000, 0, 0, 11'h000, 4'hF, 32'h0,        1, 1, 0, 0, 0, 1, 32'h0,        32'hFFFFA5A5, 1, 1};
    vecs[8]  = '{1, 1, 11'h006, 0, 0, 11'h000, 4'hF, 32'h12345678, 0, 1, 1, 1, 0, 0, 32'h0,        32'h0,        1, 1};
    vecs[9]  = '{0, 0, 11'h000, 0, 0, 11'h000, 4'hF, 32'h0,        1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0};
    vecs[10] = '{1, 0, 11'h006, 0, 0, 11'h000, 4'hF, 32'h0,        0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        2, 0};
    vecs[11] = '{0, 0, 11'h000, 0, 0, 11'h000, 4'hF, 32'h0,        1, 1, 0, 0, 1, 0, 32'h12345678, 32'h0,        2, 0};
    vecs[12] = '{0, 0, 11'h000, 1, 0, 11'h001, 4'hF, 32'h0,        1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        2, 0};
    vecs[13] = '{0, 0, 11'h000, 1, 0, 11'h002, 4'hF, 32'h0,        1, 0, 1, 0, 0, 1, 32'h0,        32'hC0DE0001, 2, 1};
    vecs[14] = '{0, 0, 11'h000, 0, 0, 11'h000, 4'hF, 32'h0,        1, 1, 0, 0, 0, 1, 32'h0,        32'hC0DE0002, 2, 1};

    // ---- reset with a request pending ----
    reset_n = 1'b0;
    drive_idle();
    model_reset();
    m0_read = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wait0", 32'(m0_waitrequest), 32'd1);
    check("rst_wait1", 32'(m1_waitrequest), 32'd1);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_mw", 32'(mem_write), 32'd0);
    check("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    check("rst_rdata0", m0_readdata, 32'd0);
    check("rst_lg", 32'(last_grant), 32'd1);
    check("rst_err", 32'(err_count), 32'd0);
    drive_idle();
    reset_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].be, vecs[i].wd,
           vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].be, vecs[i].wd);
      check($sformatf("v%0d_wait0", i), 32'(obs_w0), 32'(vecs[i].e_w0));
      check($sformatf("v%0d_wait1", i), 32'(obs_w1), 32'(vecs[i].e_w1));
      check($sformatf("v%0d_cs", i), 32'(obs_cs), 32'(vecs[i].e_cs));
      check($sformatf("v%0d_mw", i), 32'(obs_mw), 32'(vecs[i].e_mw));
      check($sformatf("v%0d_rv", i), 32'({obs_rv0, obs_rv1}), 32'({vecs[i].e_rv0, vecs[i].e_rv1}));
      check($sformatf("v%0d_rd0", i), obs_rd0, vecs[i].e_rd0);
      check($sformatf("v%0d_rd1", i), obs_rd1, vecs[i].e_rd1);
      check($sformatf("v%0d_err", i), 32'(obs_err), 32'(vecs[i].e_err));
      check($sformatf("v%0d_lg", i), 32'(obs_lg), 32'(vecs[i].e_lg));
    end

    // ---- read accepted, then reset right after the accepting edge ----
    step(0, 0, 11'h0, 4'h0, 32'h0, 1, 0, 11'h003, 4'h0, 32'h0);
    step(1, 0, 11'h010, 4'h0, 32'h0, 0, 0, 11'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    drive_idle();
    #1;
    check("rst2_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("rst2_wait0", 32'(m0_waitrequest), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst2_post_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("rst2_post_lg", 32'(last_grant), 32'd1);
    check("rst2_post_err", 32'(err_count), 32'd0);
    repeat (2) step(0, 0, 11'h0, 4'h0, 32'h0, 0, 0, 11'h0, 4'h0, 32'h0);

    // ---- error counter saturation with out-of-range writes ----
    for (int i = 0; i < 300; i++)
      step(1, 0 == 1, 11'(NW + $urandom_range(0, 511)), 4'hF, $urandom(),
           0, 0, 11'h0, 4'h0, 32'h0);
    for (int i = 0; i < 300; i++)
      step(0, 1, 11'(NW + $urandom_range(0, 511)), 4'hF, $urandom(),
           0, 0, 11'h0, 4'h0, 32'h0);
    step(0, 0, 11'h0, 4'h0, 32'h0, 0, 0, 11'h0, 4'h0, 32'h0);
    check("err_saturated", 32'(obs_err), 32'd255);
    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check("mem_unchanged_diffs", 32'(diffs), 32'd0);
    end

    // ---- randomized traffic ----
    for (int i = 0; i < 600; i++) begin
      logic [10:0] a0, a1;
      logic        r0, w0, r1, w1;
      a0 = ($urandom_range(0, 15) == 0) ? 11'(NW + $urandom_range(0, 511)) : 11'($urandom_range(0, 40));
      a1 = ($urandom_range(0, 15) == 0) ? 11'(NW + $urandom_range(0, 511)) : 11'($urandom_range(0, 40));
      r0 = $urandom_range(0, 2) != 0;  w0 = $urandom_range(0, 3) == 0;
      r1 = $urandom_range(0, 2) != 0;  w1 = $urandom_range(0, 3) == 0;
      step(r0, w0, a0, 4'($urandom_range(0, 15)), $urandom(),
           r1, w1, a1, 4'($urandom_range(0, 15)), $urandom());
    end
    repeat (2) step(0, 0, 11'h0, 4'h0, 32'h0, 0, 0, 11'h0, 4'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
